turn_controller: RTL and testbench
==================================

# turn_controller

Upstream command front-end for `game_top`. Accepts raw per-player requests and shop-ready levels, then produces the `turn`, `play_valid`/`play_action`, per-player `buy_valid`/`buy_code` and `start_round` signals that `game_top` consumes. In the play phase it enforces strict turn alternation and a per-turn inactivity timeout. It tracks `game_top`'s `phase` output to follow round start and round end.

## Interface
- `TURN_TIMEOUT`, default 200: cycles the active player may idle before losing the turn; legal range 2 to 2^TIMER_W−1.
- `TIMER_W`, default 8: width of the turn timer.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted while 0.
- `phase`  in  1  from `game_top`: 0 = PLAY, 1 = SHOP.
- `p1_req`, `p2_req`  in  1  one-cycle request strobe from each player.
- `p1_code`, `p2_code`  in  3  action/item code, sampled with the matching `req`.
- `p1_ready`, `p2_ready`  in  1  player has finished shopping (level or pulse).
- `turn`  out  1  0 = P1 active, 1 = P2 active.
- `play_valid`  out  1  one-cycle play strobe.
- `play_action`  out  3  code issued with `play_valid`.
- `buy_valid_p1`, `buy_valid_p2`  out  1  one-cycle buy strobes.
- `buy_code_p1`, `buy_code_p2`  out  3  item codes.
- `start_round`  out  1  one-cycle round-start pulse.
- `turn_timeout`  out  1  one-cycle pulse when a turn is forfeited.
- `err_not_your_turn_p1`, `err_not_your_turn_p2`  out  1  one-cycle pulse when a request from the inactive player is dropped.
- `turn_timer`  out  TIMER_W  idle cycles elapsed in the current turn.

## Operation
- **Registers:** all outputs are registered.
- **Reset values:** every output 0, state SHOP, ready flags `rdy1`/`rdy2` 0, timer 0.
- **Strobes:** every strobe is high for exactly one cycle and 0 otherwise.
- **Code handling:** codes are forwarded unmodified, including 5–7. Validity is checked downstream.
- **SHOP state:**
  - `pX_req` → next cycle `buy_valid_pX`=1 and `buy_code_pX`=`pX_code`.
  - Both players may buy in the same cycle; their paths are independent.
  - `pX_ready`=1 sets sticky `rdyX`.
  - When `rdy1`&`rdy2` are both set (registered), the FSM pulses `start_round` for one cycle, clears both flags and goes to LAUNCH.
  - A req in the same cycle as the `start_round` decision is still forwarded as a buy.
- **LAUNCH state:**
  - All reqs are dropped silently.
  - On sampling `phase`==0 → PLAY with `turn`=0 and `turn_timer`=0.
- **PLAY state (active player A = `turn`):**
  - A's req → ISSUE. Next cycle `play_valid`=1, `play_action`=code, `turn` unchanged.
  - The inactive player's req → drop it and pulse `err_not_your_turn` for that player. If both players request in the same cycle, A is forwarded and the other gets the error.
  - No A req → `turn_timer` increments.
  - No A req while `turn_timer`==TURN_TIMEOUT−1 → toggle `turn`, clear the timer, pulse `turn_timeout`. No `play_valid` is issued.
  - An A req in the limit cycle wins; no timeout occurs.
- **ISSUE state (the `play_valid` cycle):**
  - Next edge: `turn` toggles, timer clears, return to PLAY.
  - Any req during ISSUE: the inactive player's req gets the error pulse. A's req is dropped silently because the turn is already committed.
- **Round end:**
  - In PLAY or ISSUE, sampling `phase`==1 (win) → SHOP, with `turn`=0, timer 0 and ready flags cleared.
  - This check has priority over req handling in that cycle.
  - A `play_valid` already on the wire completes; `game_top` ignores it in SHOP.
- **Ignored inputs:** `pX_ready` is ignored outside SHOP.
- **Timer width:** `turn_timer` never exceeds TURN_TIMEOUT−1, so there is no wrap.

## Timing
- `pX_req` to `buy_valid_pX`: 1 cycle.
- `pX_req` to `play_valid`: 1 cycle.
- `turn` toggles 2 cycles after the accepted req edge, i.e. the edge after `play_valid`.
- `turn` is stable during every `play_valid` cycle.
- `rdy1`&`rdy2` set → `start_round` high in the next cycle.
- `game_top` flips `phase` one cycle after `start_round`. LAUNCH therefore nominally lasts 1 cycle; it waits indefinitely if `phase` stays 1.
- Maximum of one play issued every 2 cycles.
- Timeout: TURN_TIMEOUT idle cycles after a turn begins, `turn_timeout` pulses and `turn` flips on the same edge.
- Reset asserted mid-operation: all outputs drop to 0 immediately (asynchronously). Release is synchronous to the next rising `clk` edge.

## Test plan
- **Buys then start:** reset, `p1_req` code 1, `p2_req` code 3 in the same cycle. Required: next cycle both `buy_valid`=1 with `buy_code_p1`=1 and `buy_code_p2`=3. Then pulse `p1_ready` and 3 cycles later `p2_ready`. Required: exactly one `start_round` pulse, no reqs forwarded during LAUNCH, and once `phase`=0, `turn`=0.
- **Alternation:** in PLAY, P1 req code 0. Required: `play_valid`=1, `play_action`=0, `turn`=0 in the same cycle; the following cycle `turn`=1. Then P2 req code 2. Required: `play_valid` with `turn`=1, then `turn` returns to 0.
- **Wrong turn:** with `turn`=0, P2 req alone → `err_not_your_turn_p2` pulse and no `play_valid`. Then P1 and P2 req together → P1 is played and P2 gets the error.
- **Timeout:** TURN_TIMEOUT=4, no reqs. Required: `turn_timer` counts 0,1,2,3, then `turn_timeout` pulses, `turn`=1 and the timer returns to 0. A second run with the P1 req on the timer=3 cycle must produce `play_valid` and no timeout.
- **Round end:** drive `phase`=1 in the cycle after a `play_valid` with `turn`=1. Required: SHOP state, `turn`=0, ready flags cleared, and a subsequent P1 req produces `buy_valid_p1`.
- **Async reset:** assert `rst`=0 mid-ISSUE, between clock edges. Required: `play_valid`, `turn` and `turn_timer` are 0 immediately, and the block is in SHOP after release.

Source files
------------

// File: rtl/turn_controller.sv
// turn_controller: command front-end for game_top. It forwards shop buys,
// launches rounds once both players are ready, enforces strict turn
// alternation in play with an idle timeout, and follows game_top's phase.
module turn_controller #(
  parameter int unsigned TURN_TIMEOUT = 200,
  parameter int unsigned TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               phase,
  input  logic               p1_req,
  input  logic               p2_req,
  input  logic [2:0]         p1_code,
  input  logic [2:0]         p2_code,
  input  logic               p1_ready,
  input  logic               p2_ready,
  output logic               turn,
  output logic               play_valid,
  output logic [2:0]         play_action,
  output logic               buy_valid_p1,
  output logic               buy_valid_p2,
  output logic [2:0]         buy_code_p1,
  output logic [2:0]         buy_code_p2,
  output logic               start_round,
  output logic               turn_timeout,
  output logic               err_not_your_turn_p1,
  output logic               err_not_your_turn_p2,
  output logic [TIMER_W-1:0] turn_timer
);

  typedef enum logic [1:0] {StShop, StLaunch, StPlay, StIssue} state_e;

  // Last idle cycle before the active player forfeits the turn.
  localparam logic [TIMER_W-1:0] TimerLimit = TIMER_W'(TURN_TIMEOUT - 1);

  state_e               r_state, w_state_d;
  logic                 r_turn, w_turn_d;
  logic [TIMER_W-1:0]   r_timer, w_timer_d;
  logic                 r_rdy1, w_rdy1_d;
  logic                 r_rdy2, w_rdy2_d;
  logic                 r_play_valid, w_play_valid_d;
  logic [2:0]           r_play_action, w_play_action_d;
  logic                 r_buy_valid_p1, w_buy_valid_p1_d;
  logic                 r_buy_valid_p2, w_buy_valid_p2_d;
  logic [2:0]           r_buy_code_p1, w_buy_code_p1_d;
  logic [2:0]           r_buy_code_p2, w_buy_code_p2_d;
  logic                 r_start_round, w_start_round_d;
  logic                 r_turn_timeout, w_turn_timeout_d;
  logic                 r_err_p1, w_err_p1_d;
  logic                 r_err_p2, w_err_p2_d;

  // Request and code of whichever player currently holds the turn.
  logic       w_a_req;
  logic [2:0] w_a_code;

  assign w_a_req  = r_turn ? p2_req : p1_req;
  assign w_a_code = r_turn ? p2_code : p1_code;

  // Next-state and registered-output decode for the round/turn FSM.
  always_comb begin
    w_state_d        = r_state;
    w_turn_d         = r_turn;
    w_timer_d        = r_timer;
    w_rdy1_d         = r_rdy1;
    w_rdy2_d         = r_rdy2;
    w_play_valid_d   = 1'b0;
    w_play_action_d  = r_play_action;
    w_buy_valid_p1_d = 1'b0;
    w_buy_valid_p2_d = 1'b0;
    w_buy_code_p1_d  = r_buy_code_p1;
    w_buy_code_p2_d  = r_buy_code_p2;
    w_start_round_d  = 1'b0;
    w_turn_timeout_d = 1'b0;
    w_err_p1_d       = 1'b0;
    w_err_p2_d       = 1'b0;

    unique case (r_state)
      StShop: begin
        // Buy paths are independent and stay live in the launch-decision cycle.
        if (p1_req) begin
          w_buy_valid_p1_d = 1'b1;
          w_buy_code_p1_d  = p1_code;
        end
        if (p2_req) begin
          w_buy_valid_p2_d = 1'b1;
          w_buy_code_p2_d  = p2_code;
        end
        if (r_rdy1 && r_rdy2) begin
          w_start_round_d = 1'b1;
          w_rdy1_d        = 1'b0;
          w_rdy2_d        = 1'b0;
          w_state_d       = StLaunch;
        end else begin
          w_rdy1_d = r_rdy1 | p1_ready;
          w_rdy2_d = r_rdy2 | p2_ready;
        end
      end
      StLaunch: begin
        if (!phase) begin
          w_state_d = StPlay;
          w_turn_d  = 1'b0;
          w_timer_d = '0;
        end
      end
      StPlay: begin
        if (phase) begin
          w_state_d = StShop;
          w_turn_d  = 1'b0;
          w_timer_d = '0;
          w_rdy1_d  = 1'b0;
          w_rdy2_d  = 1'b0;
        end else begin
          w_err_p1_d = r_turn & p1_req;
          w_err_p2_d = ~r_turn & p2_req;
          if (w_a_req) begin
            w_state_d       = StIssue;
            w_play_valid_d  = 1'b1;
            w_play_action_d = w_a_code;
          end else if (r_timer == TimerLimit) begin
            w_turn_d         = ~r_turn;
            w_timer_d        = '0;
            w_turn_timeout_d = 1'b1;
          end else begin
            w_timer_d = r_timer + 1'b1;
          end
        end
      end
      StIssue: begin
        if (phase) begin
          w_state_d = StShop;
          w_turn_d  = 1'b0;
          w_timer_d = '0;
          w_rdy1_d  = 1'b0;
          w_rdy2_d  = 1'b0;
        end else begin
          // The active player's request is dropped silently: the turn is committed.
          w_err_p1_d = r_turn & p1_req;
          w_err_p2_d = ~r_turn & p2_req;
          w_state_d  = StPlay;
          w_turn_d   = ~r_turn;
          w_timer_d  = '0;
        end
      end
      default: w_state_d = StShop;
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= StShop;
      r_turn         <= 1'b0;
      r_timer        <= '0;
      r_rdy1         <= 1'b0;
      r_rdy2         <= 1'b0;
      r_play_valid   <= 1'b0;
      r_play_action  <= 3'd0;
      r_buy_valid_p1 <= 1'b0;
      r_buy_valid_p2 <= 1'b0;
      r_buy_code_p1  <= 3'd0;
      r_buy_code_p2  <= 3'd0;
      r_start_round  <= 1'b0;
      r_turn_timeout <= 1'b0;
      r_err_p1       <= 1'b0;
      r_err_p2       <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_turn         <= w_turn_d;
      r_timer        <= w_timer_d;
      r_rdy1         <= w_rdy1_d;
      r_rdy2         <= w_rdy2_d;
      r_play_valid   <= w_play_valid_d;
      r_play_action  <= w_play_action_d;
      r_buy_valid_p1 <= w_buy_valid_p1_d;
      r_buy_valid_p2 <= w_buy_valid_p2_d;
      r_buy_code_p1  <= w_buy_code_p1_d;
      r_buy_code_p2  <= w_buy_code_p2_d;
      r_start_round  <= w_start_round_d;
      r_turn_timeout <= w_turn_timeout_d;
      r_err_p1       <= w_err_p1_d;
      r_err_p2       <= w_err_p2_d;
    end
  end

  assign turn                 = r_turn;
  assign play_valid           = r_play_valid;
  assign play_action          = r_play_action;
  assign buy_valid_p1         = r_buy_valid_p1;
  assign buy_valid_p2         = r_buy_valid_p2;
  assign buy_code_p1          = r_buy_code_p1;
  assign buy_code_p2          = r_buy_code_p2;
  assign start_round          = r_start_round;
  assign turn_timeout         = r_turn_timeout;
  assign err_not_your_turn_p1 = r_err_p1;
  assign err_not_your_turn_p2 = r_err_p2;
  assign turn_timer           = r_timer;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: stimulus pushes expected strobe events
// (kind, code, turn, cycle); a negedge monitor pops one per observed strobe.
module tb_turn_controller;

  localparam int unsigned TO = 4;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          phase = 1'b1;
  logic          p1_req = 1'b0;
  logic          p2_req = 1'b0;
  logic [2:0]    p1_code = 3'd0;
  logic [2:0]    p2_code = 3'd0;
  logic          p1_ready = 1'b0;
  logic          p2_ready = 1'b0;
  logic          turn, play_valid, buy_valid_p1, buy_valid_p2;
  logic          start_round, turn_timeout, err_not_your_turn_p1, err_not_your_turn_p2;
  logic [2:0]    play_action, buy_code_p1, buy_code_p2;
  logic [TW-1:0] turn_timer;

  turn_controller #(.TURN_TIMEOUT(TO), .TIMER_W(TW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .phase                (phase),
    .p1_req               (p1_req),
    .p2_req               (p2_req),
    .p1_code              (p1_code),
    .p2_code              (p2_code),
    .p1_ready             (p1_ready),
    .p2_ready             (p2_ready),
    .turn                 (turn),
    .play_valid           (play_valid),
    .play_action          (play_action),
    .buy_valid_p1         (buy_valid_p1),
    .buy_valid_p2         (buy_valid_p2),
    .buy_code_p1          (buy_code_p1),
    .buy_code_p2          (buy_code_p2),
    .start_round          (start_round),
    .turn_timeout         (turn_timeout),
    .err_not_your_turn_p1 (err_not_your_turn_p1),
    .err_not_your_turn_p2 (err_not_your_turn_p2),
    .turn_timer           (turn_timer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef enum logic [2:0] {EvBuy1, EvBuy2, EvPlay, EvStart, EvTimeout, EvErr1, EvErr2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [2:0] data;
    logic       turn;
    int         cyc;
  } ev_t;

  ev_t sb_q[$];

  // Expected strobe one cycle after the inputs driven at this step.
  task automatic expect_ev(input ev_kind_e k, input logic [2:0] d, input logic t);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.turn = t;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [2:0] d, input logic t);
    ev_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got %s code=%0d turn=%0d cyc=%0d required none",
               k.name(), d, t, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.data != d || e.turn != t || e.cyc != cyc) begin
        bad++;
        $display("FAIL event got %s code=%0d turn=%0d cyc=%0d required %s code=%0d turn=%0d cyc=%0d",
                 k.name(), d, t, cyc, e.kind.name(), e.data, e.turn, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe seen must match the head of the scoreboard.
  always @(negedge clk) begin
    if (buy_valid_p1)         observe(EvBuy1, buy_code_p1, turn);
    if (buy_valid_p2)         observe(EvBuy2, buy_code_p2, turn);
    if (play_valid)           observe(EvPlay, play_action, turn);
    if (start_round)          observe(EvStart, 3'd0, turn);
    if (turn_timeout)         observe(EvTimeout, 3'd0, turn);
    if (err_not_your_turn_p1) observe(EvErr1, 3'd0, turn);
    if (err_not_your_turn_p2) observe(EvErr2, 3'd0, turn);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick();
    tick();
    check("rst_turn", int'(turn), 0);
    check("rst_play_valid", int'(play_valid), 0);
    check("rst_timer", int'(turn_timer), 0);
    check("rst_start_round", int'(start_round), 0);
    check("rst_buy_valid_p1", int'(buy_valid_p1), 0);
    check("rst_turn_timeout", int'(turn_timeout), 0);
    rst = 1'b1;
    tick();

    // Simultaneous buys in SHOP.
    p1_req = 1'b1; p1_code = 3'd1; p2_req = 1'b1; p2_code = 3'd3;
    expect_ev(EvBuy1, 3'd1, 1'b0);
    expect_ev(EvBuy2, 3'd3, 1'b0);
    tick();
    p1_req = 1'b0; p2_req = 1'b0;
    p1_ready = 1'b1;
    tick();
    p1_ready = 1'b0;
    tick();
    tick();
    p2_ready = 1'b1;
    tick();
    p2_ready = 1'b0;
    // Decision cycle: start_round next, a same-cycle buy is still forwarded.
    p1_req = 1'b1; p1_code = 3'd5;
    expect_ev(EvBuy1, 3'd5, 1'b0);
    expect_ev(EvStart, 3'd0, 1'b0);
    tick();
    // LAUNCH with phase still 1: requests dropped.
    p1_req = 1'b1; p2_req = 1'b1; p1_code = 3'd2; p2_code = 3'd2;
    tick();
    phase = 1'b0;
    tick();
    p1_req = 1'b0; p2_req = 1'b0;
    check("launch_turn", int'(turn), 0);
    check("launch_timer", int'(turn_timer), 0);

    // Alternation.
    p1_req = 1'b1; p1_code = 3'd0;
    expect_ev(EvPlay, 3'd0, 1'b0);
    tick();
    p1_req = 1'b0;
    check("issue1_turn", int'(turn), 0);
    tick();
    check("alt_turn_p2", int'(turn), 1);
    check("alt_timer", int'(turn_timer), 0);
    p2_req = 1'b1; p2_code = 3'd2;
    expect_ev(EvPlay, 3'd2, 1'b1);
    tick();
    p2_req = 1'b0;
    check("issue2_turn", int'(turn), 1);
    tick();
    check("alt_turn_p1", int'(turn), 0);

    // Wrong turn, then both together, then both during ISSUE.
    p2_req = 1'b1; p2_code = 3'd6;
    expect_ev(EvErr2, 3'd0, 1'b0);
    tick();
    p2_req = 1'b0;
    check("wrong_timer", int'(turn_timer), 1);
    check("wrong_turn", int'(turn), 0);
    p1_req = 1'b1; p1_code = 3'd7; p2_req = 1'b1; p2_code = 3'd4;
    expect_ev(EvPlay, 3'd7, 1'b0);
    expect_ev(EvErr2, 3'd0, 1'b0);
    tick();
    expect_ev(EvErr2, 3'd0, 1'b1);
    tick();
    p1_req = 1'b0; p2_req = 1'b0;
    check("after_both_turn", int'(turn), 1);
    check("after_both_timer", int'(turn_timer), 0);
    p2_req = 1'b1; p2_code = 3'd3;
    expect_ev(EvPlay, 3'd3, 1'b1);
    tick();
    p2_req = 1'b0;
    tick();

    // Idle timeout from turn 0.
    for (int i = 0; i < 4; i++) begin
      check("to_timer", int'(turn_timer), i);
      check("to_turn", int'(turn), 0);
      if (i == 3) expect_ev(EvTimeout, 3'd0, 1'b1);
      tick();
    end
    check("after_to_turn", int'(turn), 1);
    check("after_to_timer", int'(turn_timer), 0);

    // Request in the limit cycle wins over the timeout.
    tick();
    tick();
    tick();
    check("limit_timer", int'(turn_timer), 3);
    p2_req = 1'b1; p2_code = 3'd1;
    expect_ev(EvPlay, 3'd1, 1'b1);
    tick();
    p2_req = 1'b0;
    tick();
    check("limit_turn", int'(turn), 0);
    check("limit_timer_clr", int'(turn_timer), 0);

    // Round end from PLAY with turn 1; ready outside SHOP ignored.
    p1_req = 1'b1; p1_code = 3'd4; p1_ready = 1'b1;
    expect_ev(EvPlay, 3'd4, 1'b0);
    tick();
    p1_req = 1'b0; p1_ready = 1'b0;
    tick();
    check("pre_end_turn", int'(turn), 1);
    phase = 1'b1; p1_req = 1'b1; p2_req = 1'b1; p2_code = 3'd5;
    tick();
    p1_req = 1'b0; p2_req = 1'b0;
    check("end_turn", int'(turn), 0);
    check("end_timer", int'(turn_timer), 0);
    p2_ready = 1'b1;
    tick();
    p2_ready = 1'b0;
    tick();
    tick();
    tick();
    p1_req = 1'b1; p1_code = 3'd6;
    expect_ev(EvBuy1, 3'd6, 1'b0);
    tick();
    p1_req = 1'b0;

    // New round, then asynchronous reset in the middle of ISSUE.
    p1_ready = 1'b1;
    tick();
    p1_ready = 1'b0;
    expect_ev(EvStart, 3'd0, 1'b0);
    tick();
    phase = 1'b0;
    tick();
    p1_req = 1'b1; p1_code = 3'd1;
    expect_ev(EvPlay, 3'd1, 1'b0);
    tick();
    p1_req = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_timer", int'(turn_timer), 2);
    p2_req = 1'b1; p2_code = 3'd2;
    expect_ev(EvPlay, 3'd2, 1'b1);
    tick();
    p2_req = 1'b0;
    check("issue_turn_pre_rst", int'(turn), 1);
    check("issue_timer_pre_rst", int'(turn_timer), 2);
    #2 rst = 1'b0;
    #1;
    check("arst_play_valid", int'(play_valid), 0);
    check("arst_turn", int'(turn), 0);
    check("arst_timer", int'(turn_timer), 0);
    phase = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    p2_req = 1'b1; p2_code = 3'd7;
    expect_ev(EvBuy2, 3'd7, 1'b0);
    tick();
    p2_req = 1'b0;
    tick();
    tick();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got %0d pending required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
